// File: rtl/grad_dac_serialiser.sv
// Gradient DAC serialiser: turns 32-bit words from grad_bram into 24-bit SPI frames on one of
// four DAC data lines, with an optional LDAC pulse after each frame. A one-word holding
// register absorbs a word that arrives while a frame is in flight.
module grad_dac_serialiser #(
  parameter int unsigned SCLK_DIV   = 2,  // sclk half-period in clk cycles (1..15)
  parameter int unsigned CSN_SETUP  = 2,  // csn low to first sclk rise (1..15)
  parameter int unsigned CSN_GAP    = 2,  // minimum csn high time between frames (1..15)
  parameter int unsigned LDAC_WIDTH = 2   // ldacn low pulse width (1..15)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_i,
  input  logic        valid_i,
  output logic        busy_o,
  output logic        active_o,
  output logic        overflow_o,
  output logic        sclk_o,
  output logic        csn_o,
  output logic [3:0]  sdo_o,
  output logic        ldacn_o
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSetup = 3'd1;
  localparam logic [2:0] StShift = 3'd2;
  localparam logic [2:0] StHold  = 3'd3;
  localparam logic [2:0] StGap   = 3'd4;

  localparam int unsigned GapLdac = (CSN_GAP > LDAC_WIDTH) ? CSN_GAP : LDAC_WIDTH;

  localparam logic [3:0] SetupLast   = 4'(CSN_SETUP - 1);
  localparam logic [3:0] DivLast     = 4'(SCLK_DIV - 1);
  localparam logic [3:0] GapLastNorm = 4'(CSN_GAP - 1);
  localparam logic [3:0] GapLastLdac = 4'(GapLdac - 1);
  localparam logic [3:0] LdacLen     = 4'(LDAC_WIDTH);
  localparam logic [4:0] BitsPerWord = 5'd24;

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;        // phase counter within the current state
  logic [4:0]  bit_q, bit_d;        // number of sclk falling edges seen in SHIFT
  logic        sclk_hi_q, sclk_hi_d;
  logic [23:0] shreg_q, shreg_d;
  logic [1:0]  ch_q, ch_d;
  logic        ldac_q, ldac_d;
  logic [26:0] hold_q, hold_d;      // {ldac, channel, frame}
  logic        hold_full_q, hold_full_d;
  logic        overflow_q, overflow_d;

  logic [3:0]  gap_last_cnt;
  logic        gap_last;
  logic        load_held;
  logic        accept_shift;
  logic        accept_hold;
  logic        framing;

  // Upper word bits carry nothing for this block.
  logic unused_data;
  assign unused_data = ^data_i[31:27];

  // Accept/drop decisions; the holding register may be refilled in the cycle it is vacated.
  always_comb begin
    gap_last_cnt = ldac_q ? GapLastLdac : GapLastNorm;
    gap_last     = (state_q == StGap) && (cnt_q == gap_last_cnt);
    load_held    = gap_last && hold_full_q;
    accept_shift = valid_i && (state_q == StIdle);
    accept_hold  = valid_i && (state_q != StIdle) && (!hold_full_q || load_held);
  end

  // Frame sequencer next-state logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sclk_hi_d = sclk_hi_q;
    shreg_d   = shreg_q;
    ch_d      = ch_q;
    ldac_d    = ldac_q;
    case (state_q)
      StIdle: begin
        if (accept_shift) begin
          shreg_d = data_i[23:0];
          ch_d    = data_i[25:24];
          ldac_d  = data_i[26];
          cnt_d   = 4'd0;
          bit_d   = 5'd0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          cnt_d     = 4'd0;
          sclk_hi_d = 1'b1;
          state_d   = StShift;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StShift: begin
        if (cnt_q == DivLast) begin
          cnt_d = 4'd0;
          if (sclk_hi_q) begin
            // Falling sclk edge: present the next bit.
            sclk_hi_d = 1'b0;
            shreg_d   = {shreg_q[22:0], 1'b0};
            bit_d     = bit_q + 5'd1;
          end else if (bit_q == BitsPerWord) begin
            state_d = StHold;
          end else begin
            sclk_hi_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StHold: begin
        if (cnt_q == DivLast) begin
          cnt_d   = 4'd0;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StGap: begin
        if (gap_last) begin
          cnt_d = 4'd0;
          if (hold_full_q) begin
            shreg_d = hold_q[23:0];
            ch_d    = hold_q[25:24];
            ldac_d  = hold_q[26];
            bit_d   = 5'd0;
            state_d = StSetup;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = StIdle;
      end
    endcase
  end

  // Holding register and sticky overflow next-state.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (accept_hold) begin
      hold_d      = data_i[26:0];
      hold_full_d = 1'b1;
    end else if (load_held) begin
      hold_full_d = 1'b0;
    end
    overflow_d = overflow_q || (valid_i && !accept_shift && !accept_hold);
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      bit_q       <= 5'd0;
      sclk_hi_q   <= 1'b0;
      shreg_q     <= 24'd0;
      ch_q        <= 2'd0;
      ldac_q      <= 1'b0;
      hold_q      <= 27'd0;
      hold_full_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      sclk_hi_q   <= sclk_hi_d;
      shreg_q     <= shreg_d;
      ch_q        <= ch_d;
      ldac_q      <= ldac_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      overflow_q  <= overflow_d;
    end
  end

  // Pin decode from registered state so reset reaches the pins without waiting for a clock.
  always_comb begin
    framing    = (state_q == StSetup) || (state_q == StShift) || (state_q == StHold);
    busy_o     = hold_full_q;
    active_o   = (state_q != StIdle);
    overflow_o = overflow_q;
    csn_o      = !framing;
    sclk_o     = (state_q == StShift) && sclk_hi_q;
    for (int i = 0; i < 4; i++) begin
      sdo_o[i] = framing && (ch_q == 2'(i)) && shreg_q[23];
    end
    ldacn_o    = !((state_q == StGap) && ldac_q && (cnt_q < LdacLen));
  end

endmodule

// File: tb/tb_grad_dac_serialiser.sv
// Scoreboard bench for grad_dac_serialiser: stimulus pushes hand-computed frames, a monitor
// reconstructs frames from the SPI pins of two DUT instances and compares.
module tb_grad_dac_serialiser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = 32'd0;
  logic [1:0]  valid = 2'b00;
  logic [1:0]  busy, active, ovf, sclk, csn, ldacn;
  logic [7:0]  sdo_all;

  always #5 clk = ~clk;

  grad_dac_serialiser dut_a (
    .clk       (clk),
    .rst       (rst),
    .data_i    (data),
    .valid_i   (valid[0]),
    .busy_o    (busy[0]),
    .active_o  (active[0]),
    .overflow_o(ovf[0]),
    .sclk_o    (sclk[0]),
    .csn_o     (csn[0]),
    .sdo_o     (sdo_all[3:0]),
    .ldacn_o   (ldacn[0])
  );

  grad_dac_serialiser #(
    .SCLK_DIV  (1),
    .CSN_SETUP (2),
    .CSN_GAP   (2),
    .LDAC_WIDTH(4)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .data_i    (data),
    .valid_i   (valid[1]),
    .busy_o    (busy[1]),
    .active_o  (active[1]),
    .overflow_o(ovf[1]),
    .sclk_o    (sclk[1]),
    .csn_o     (csn[1]),
    .sdo_o     (sdo_all[7:4]),
    .ldacn_o   (ldacn[1])
  );

  typedef struct {
    int          dut;
    logic [1:0]  ch;
    logic [23:0] data;
    int          low_len;
    int          gap_len;
    int          ldac_len;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_fail = 0;

  // Monitor state, one slot per DUT.
  bit          in_frame[2];
  bit          in_gap[2];
  bit          ldac_in_frame[2];
  logic        prev_csn[2];
  logic        prev_sclk[2];
  int          low_cnt[2];
  int          rises[2];
  int          gap_cnt[2];
  int          ldac_cnt[2];
  logic [23:0] cap[2][4];
  logic [3:0]  seen[2];
  exp_t        cur[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(int d, logic [31:0] w, int low, int gap, int ld);
    exp_t e;
    e.dut      = d;
    e.ch       = w[25:24];
    e.data     = w[23:0];
    e.low_len  = low;
    e.gap_len  = gap;
    e.ldac_len = ld;
    return e;
  endfunction

  task automatic monitor();
    logic       c, s, l, a;
    logic [3:0] o;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        c = csn[d];
        s = sclk[d];
        l = ldacn[d];
        a = active[d];
        o = sdo_all[d*4 +: 4];
        if (rst) begin
          in_frame[d]  = 1'b0;
          in_gap[d]    = 1'b0;
          prev_csn[d]  = 1'b1;
          prev_sclk[d] = 1'b0;
        end else begin
          if (in_gap[d]) begin
            if (c && a) begin
              gap_cnt[d]++;
              if (!l) ldac_cnt[d]++;
            end else begin
              check($sformatf("gap_len d%0d", d), 64'(gap_cnt[d]), 64'(cur[d].gap_len));
              check($sformatf("ldac_len d%0d", d), 64'(ldac_cnt[d]), 64'(cur[d].ldac_len));
              in_gap[d] = 1'b0;
            end
          end
          if (in_frame[d]) begin
            if (!c) begin
              low_cnt[d]++;
              if (s && !prev_sclk[d]) begin
                rises[d]++;
                for (int k = 0; k < 4; k++) cap[d][k] = {cap[d][k][22:0], o[k]};
              end
              seen[d] = seen[d] | o;
              if (!l) ldac_in_frame[d] = 1'b1;
            end else begin
              in_frame[d] = 1'b0;
              if (exp_q.size() == 0 || exp_q[0].dut != d) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_frame d%0d: got a frame, expected none (t=%0t)",
                         d, $time);
              end else begin
                cur[d] = exp_q.pop_front();
                check($sformatf("csn_low d%0d", d), 64'(low_cnt[d]), 64'(cur[d].low_len));
                check($sformatf("sclk_rises d%0d", d), 64'(rises[d]), 64'd24);
                check($sformatf("sdo_data d%0d", d), 64'(cap[d][cur[d].ch]),
                      64'(cur[d].data));
                check($sformatf("other_lines d%0d", d),
                      64'(seen[d] & ~(4'b0001 << cur[d].ch)), 64'd0);
                check($sformatf("ldac_in_frame d%0d", d), 64'(ldac_in_frame[d]), 64'd0);
                in_gap[d]   = 1'b1;
                gap_cnt[d]  = 1;
                ldac_cnt[d] = l ? 0 : 1;
              end
            end
          end else if (prev_csn[d] && !c) begin
            in_frame[d]      = 1'b1;
            low_cnt[d]       = 1;
            rises[d]         = 0;
            for (int k = 0; k < 4; k++) cap[d][k] = 24'd0;
            seen[d]          = o;
            ldac_in_frame[d] = !l;
          end
          prev_csn[d]  = c;
          prev_sclk[d] = s;
        end
      end
    end
  endtask

  // Called at #1 after a posedge; the next posedge samples the word.
  task automatic strobe(input int d, input logic [31:0] w);
    data     = w;
    valid[d] = 1'b1;
    @(posedge clk);
    #1;
    valid[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    repeat (2) @(posedge clk);
    while (active[d] && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check($sformatf("idle_within_budget d%0d", d), 64'(n < 1000), 64'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int r;
    logic ps;
    fork
      monitor();
    join_none

    // Reset state on both instances.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_pins d%0d", d),
            64'({csn[d], ldacn[d], sclk[d], busy[d], active[d], ovf[d], sdo_all[d*4 +: 4]}),
            64'(10'b1100000000));
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: single word on channel 1.
    exp_q.push_back(mk(0, 32'h015A5A5A, 100, 2, 0));
    strobe(0, 32'h015A5A5A);
    check("csn_falls_after_strobe", 64'(csn[0]), 64'd0);
    wait_idle(0);

    // 2: LDAC request on channel 0.
    exp_q.push_back(mk(0, 32'h04800000, 100, 2, 2));
    strobe(0, 32'h04800000);
    wait_idle(0);

    // 3: back-to-back words four cycles apart.
    exp_q.push_back(mk(0, 32'h00000001, 100, 2, 0));
    strobe(0, 32'h00000001);
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(mk(0, 32'h03FFFFFF, 100, 2, 0));
    strobe(0, 32'h03FFFFFF);
    n = 0;
    while (busy[0] && n < 300) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("busy_cycles", 64'(n), 64'd98);
    wait_idle(0);

    // 4: third strobe inside one frame is dropped.
    exp_q.push_back(mk(0, 32'h01000F0F, 100, 2, 0));
    strobe(0, 32'h01000F0F);
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(mk(0, 32'h02F0F0F0, 100, 2, 0));
    strobe(0, 32'h02F0F0F0);
    repeat (3) @(posedge clk);
    #1;
    check("overflow_before_drop", 64'(ovf[0]), 64'd0);
    strobe(0, 32'h03ABCDEF);
    check("overflow_after_drop", 64'(ovf[0]), 64'd1);
    wait_idle(0);
    check("overflow_sticky", 64'(ovf[0]), 64'd1);

    // 5: reset at bit 10 of a frame, then a clean frame.
    strobe(0, 32'h03000AAA);
    r  = 0;
    n  = 0;
    ps = 1'b0;
    while (r < 10 && n < 500) begin
      @(negedge clk);
      if (sclk[0] && !ps) r++;
      ps = sclk[0];
      n++;
    end
    check("reached_bit10", 64'(r), 64'd10);
    check("csn_low_at_bit10", 64'(csn[0]), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("midframe_reset_pins",
          64'({csn[0], ldacn[0], sclk[0], busy[0], active[0], ovf[0], sdo_all[3:0]}),
          64'(10'b1100000000));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(mk(0, 32'h02123456, 100, 2, 0));
    strobe(0, 32'h02123456);
    wait_idle(0);

    // 6: SCLK_DIV=1, LDAC_WIDTH=4 instance, with and without LDAC.
    exp_q.push_back(mk(1, 32'h05ABCDEF, 51, 4, 4));
    strobe(1, 32'h05ABCDEF);
    wait_idle(1);
    exp_q.push_back(mk(1, 32'h0200C3A5, 51, 2, 0));
    strobe(1, 32'h0200C3A5);
    wait_idle(1);

    check("frames_outstanding", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
